// File: rtl/prng_pkg.sv
// Shared types and constants for the random-byte scheduler slice.
package prng_pkg;

    localparam int unsigned DIV_W = 24;
    localparam int unsigned N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2,
        GRANT  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter producing a one-cycle tick on its last count.
module tick_divider
    import prng_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV = 24'd1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV - DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == LAST);

    // Count 0..DIV-1 and wrap; a clear restarts the sequence at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || at_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // With DIV=1 the counter sits on its last value permanently, so the tick
    // must be suppressed explicitly while held in reset or cleared.
    assign tick = at_last & ~clr & rst_n;

endmodule

// File: rtl/prng_scheduler.sv
// Step-enable generator for the data/control LFSRs plus a round-robin
// arbiter that forces a fresh LFSR step before handing out each byte.
module prng_scheduler
    import prng_pkg::*;
#(
    parameter logic [DIV_W-1:0] DATA_DIV = 24'd10_000_000,
    parameter logic [DIV_W-1:0] CTRL_DIV = 24'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_REQ-1:0] req,
    input  logic [7:0]       mux_byte,
    output logic             step_data,
    output logic             step_ctrl,
    output logic [N_REQ-1:0] gnt,
    output logic [7:0]       rnd_data,
    output logic             busy
);

    sched_state_t state;
    logic         winner;
    logic         last;
    logic         pick;
    logic [7:0]   rnd_q;
    logic         tick_d;
    logic         tick_c;
    logic         force_step;
    logic         grant_ok;

    tick_divider #(.DIV(DATA_DIV)) u_div_data (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~ena),
        .tick  (tick_d)
    );

    tick_divider #(.DIV(CTRL_DIV)) u_div_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~ena),
        .tick  (tick_c)
    );

    // Winner selection: on a tie take the requester not served last.
    always_comb begin
        pick = 1'b0;
        if (req == '1) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
    end

    // Arbiter FSM; ena low acts as a soft clear but keeps last and rnd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            winner <= 1'b0;
            last   <= 1'b1;
            rnd_q  <= '0;
        end else if (!ena) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner <= pick;
                        state  <= STEP;
                    end
                end
                STEP: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    rnd_q <= mux_byte;
                    state <= GRANT;
                end
                GRANT: begin
                    last  <= winner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign force_step = ena & (state == STEP);
    assign grant_ok   = ena & (state == GRANT);

    // OR-ing tick and forced step yields one step even when they coincide.
    assign step_data = tick_d | force_step;
    assign step_ctrl = tick_c | force_step;

    // One-hot grant decoded from the registered winner.
    always_comb begin
        gnt         = '0;
        gnt[winner] = grant_ok;
    end

    assign rnd_data = rnd_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_prng_scheduler.sv
// Directed self-checking bench for prng_scheduler.
module tb_prng_scheduler;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] req;
    logic [7:0] mux_byte;
    logic       step_data;
    logic       step_ctrl;
    logic [1:0] gnt;
    logic [7:0] rnd_data;
    logic       busy;

    logic [1:0] req1;
    logic [7:0] mux_byte1;
    logic       step_data1;
    logic       step_ctrl1;
    logic [1:0] gnt1;
    logic [7:0] rnd_data1;
    logic       busy1;

    int n_vec;
    int n_err;

    prng_scheduler #(.DATA_DIV(24'd5), .CTRL_DIV(24'd2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .mux_byte  (mux_byte),
        .step_data (step_data),
        .step_ctrl (step_ctrl),
        .gnt       (gnt),
        .rnd_data  (rnd_data),
        .busy      (busy)
    );

    prng_scheduler #(.DATA_DIV(24'd3), .CTRL_DIV(24'd1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req1),
        .mux_byte  (mux_byte1),
        .step_data (step_data1),
        .step_ctrl (step_ctrl1),
        .gnt       (gnt1),
        .rnd_data  (rnd_data1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n_d;
        int n_c;
        int n_c1;
        logic [1:0] exp_g;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ena = 1'b1;
        req = 2'b00;
        mux_byte = 8'h00;
        req1 = 2'b00;
        mux_byte1 = 8'h00;

        repeat (2) cyc();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rnd", 32'(rnd_data), 32'h0);
        chk("rst_step_d", 32'(step_data), 32'h0);
        chk("rst_step_c", 32'(step_ctrl), 32'h0);
        chk("rst_step_c1", 32'(step_ctrl1), 32'h0);

        // Divider rates: DATA_DIV=5, CTRL_DIV=2 over 40 enabled cycles.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_d = 0;
        n_c = 0;
        for (int i = 1; i <= 40; i++) begin
            chk($sformatf("div_d_%0d", i), 32'(step_data), 32'((i % 5) == 0));
            chk($sformatf("div_c_%0d", i), 32'(step_ctrl), 32'((i % 2) == 0));
            n_d += int'(step_data);
            n_c += int'(step_ctrl);
            cyc();
        end
        chk("div_d_count", 32'(n_d), 32'd8);
        chk("div_c_count", 32'(n_c), 32'd20);

        // Single request on port 0.
        mux_byte = 8'h3C;
        req = 2'b01;
        cyc();
        chk("single_step_d", 32'(step_data), 32'h1);
        chk("single_step_c", 32'(step_ctrl), 32'h1);
        chk("single_busy1", 32'(busy), 32'h1);
        chk("single_gnt1", 32'(gnt), 32'h0);
        cyc();
        chk("single_busy2", 32'(busy), 32'h1);
        chk("single_gnt2", 32'(gnt), 32'h0);
        mux_byte = 8'hA5;
        cyc();
        chk("single_gnt3", 32'(gnt), 32'h1);
        chk("single_rnd3", 32'(rnd_data), 32'hA5);
        chk("single_busy3", 32'(busy), 32'h1);
        req = 2'b00;
        cyc();
        chk("single_busy4", 32'(busy), 32'h0);
        chk("single_gnt4", 32'(gnt), 32'h0);
        chk("single_rnd_hold", 32'(rnd_data), 32'hA5);

        // Round robin straight out of reset.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        mux_byte = 8'h11;
        req = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 3 || k == 11)      exp_g = 2'b01;
            else if (k == 7 || k == 15) exp_g = 2'b10;
            else                        exp_g = 2'b00;
            chk($sformatf("rr_gnt_%0d", k), 32'(gnt), 32'(exp_g));
            if (k == 3) chk("rr_rnd", 32'(rnd_data), 32'h11);
        end
        req = 2'b00;

        // Enable dropped in SETTLE, restored three cycles later.
        mux_byte = 8'h5A;
        req = 2'b10;
        cyc();
        chk("en_step_busy", 32'(busy), 32'h1);
        cyc();
        chk("en_settle_busy", 32'(busy), 32'h1);
        ena = 1'b0;
        cyc();
        chk("en_off_busy", 32'(busy), 32'h0);
        chk("en_off_cnt_d", 32'(u_dut.u_div_data.cnt), 32'h0);
        chk("en_off_cnt_c", 32'(u_dut.u_div_ctrl.cnt), 32'h0);
        chk("en_off_rnd", 32'(rnd_data), 32'h11);
        for (int k = 3; k <= 5; k++) begin
            if (k > 3) cyc();
            chk($sformatf("en_off_gnt_%0d", k), 32'(gnt), 32'h0);
            chk($sformatf("en_off_sd_%0d", k), 32'(step_data), 32'h0);
            chk($sformatf("en_off_sc_%0d", k), 32'(step_ctrl), 32'h0);
            chk($sformatf("en_off_sc1_%0d", k), 32'(step_ctrl1), 32'h0);
        end
        ena = 1'b1;
        cyc();
        chk("en_on_step_d", 32'(step_data), 32'h1);
        chk("en_on_step_c", 32'(step_ctrl), 32'h1);
        cyc();
        chk("en_on_gnt_early", 32'(gnt), 32'h0);
        cyc();
        chk("en_on_gnt", 32'(gnt), 32'h2);
        chk("en_on_rnd", 32'(rnd_data), 32'h5A);
        req = 2'b00;
        cyc();

        // Forced step coinciding with a CTRL_DIV=1 tick.
        mux_byte1 = 8'hC3;
        req1 = 2'b01;
        n_c1 = 0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_c1 += int'(step_ctrl1);
            if (k == 1) begin
                chk("coin_step_c", 32'(step_ctrl1), 32'h1);
                chk("coin_step_d", 32'(step_data1), 32'h1);
                chk("coin_busy", 32'(busy1), 32'h1);
            end
            if (k == 3) begin
                chk("coin_gnt", 32'(gnt1), 32'h1);
                chk("coin_rnd", 32'(rnd_data1), 32'hC3);
                req1 = 2'b00;
            end
        end
        chk("coin_ctrl_steps", 32'(n_c1), 32'd4);

        // Asynchronous reset in the middle of GRANT.
        mux_byte = 8'h77;
        req = 2'b01;
        repeat (3) cyc();
        chk("ar_pre_gnt", 32'(gnt), 32'h1);
        chk("ar_pre_rnd", 32'(rnd_data), 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_step_d", 32'(step_data), 32'h0);
        chk("ar_step_c", 32'(step_ctrl), 32'h0);
        chk("ar_step_c1", 32'(step_ctrl1), 32'h0);
        chk("ar_rnd", 32'(rnd_data), 32'h0);
        req = 2'b00;
        cyc();
        rst_n = 1'b1;
        req = 2'b11;
        repeat (3) cyc();
        chk("ar_tie_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
